la_grparb222: RTL and testbench
===============================

Name: la_grparb222

Overview:
- Registered two-level round-robin arbiter for one shared resource with six requesters.
- Requesters form three groups of two: a0/a1, b0/b1, c0/c1.
- Groups rotate fairly among themselves; members rotate fairly within their group.
- Owner keeps the grant until it drops its request or exceeds a hold limit.
- Also gives a registered "every group requesting" flag, the complement of the or-and-invert 222 function of the requests, used by the power/clock sequencers.

Parameters:
- PROP, "DEFAULT", implementation property string passed to the cell library.
- HOLD_MAX, 16, maximum consecutive grant cycles before forced rotation when others wait; 0 means unlimited. Valid range 0..255.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- nreset  input  1  asynchronous active-low reset
- req  input  6  request vector; bit 2*g+m, where group g is a=0, b=1, c=2 and member m is 0 or 1
- gnt  output  6  one-hot registered grant, same bit layout as req
- gnt_valid  output  1  high when any gnt bit is set
- gnt_id  output  3  index of the granted bit; 0 when gnt_valid is low
- preempt  output  1  one-cycle pulse in the cycle a forced rotation takes effect
- all_req  output  1  registered value of (a0|a1)&(b0|b1)&(c0|c1)

Behaviour:
- Reset (async assert, sync release): gnt=0, gnt_valid=0, gnt_id=0, preempt=0, all_req=0, hold_cnt=0, state=IDLE.
- Reset values also set the pointers: gptr=2 so group a wins first, and mptr[0..2]=1 so member 0 wins first.
- Grant selection:
  - Scan groups starting at gptr+1 mod 3 and pick the first group with any eligible request.
  - Within that group, scan from member mptr[g]^1.
  - "Eligible" excludes the current owner when rotating.
- FSM IDLE:
  - On an edge where req!=0, issue the winner: gnt, gnt_id and gnt_valid update at that edge, so latency is one cycle from req sampled high.
  - Go to GRANT. Set gptr=g and mptr[g]=m. Set hold_cnt=1.
- FSM GRANT, owner req sampled low:
  - If another eligible request exists, hand off directly to the new winner at the same edge (no idle bubble) and update the pointers.
  - Otherwise gnt=0 and go to IDLE.
- FSM GRANT, owner req high:
  - If HOLD_MAX!=0, hold_cnt>=HOLD_MAX and another requester is pending: force rotation to that winner, pulse preempt=1 for one cycle, set hold_cnt=1.
  - If no other requester is pending: keep the grant; hold_cnt saturates at HOLD_MAX.
  - Otherwise hold_cnt increments.
- Grant is never given to a requester whose req was low at the sampling edge.
- gnt is always 0 or one-hot.
- Pointers change only when a grant is issued.
- all_req is registered from req every cycle, independent of the FSM.
- Reset asserted mid-grant clears everything immediately; the first grant after release again favours a0.
- hold_cnt width is 8 bits.

Test Plan:
- Reset, then req=6'b111111 on the same cycle -> next edge gnt=6'b000001, gnt_id=0, gnt_valid=1; all_req=1 one cycle after req.
- Fairness with all six requesting: each owner drops req one cycle after its grant and re-raises it the next cycle -> grant order a0,b0,c0,a1,b1,c1,a0, with no idle cycle between grants.
- Preemption with HOLD_MAX=4: req[0] held from reset; req[3] raised at cycle 2 -> gnt[0] for 4 cycles, then gnt=6'b001000 with preempt=1 for exactly one cycle.
- No preemption for a lone requester: only req[5] held for 40 cycles -> gnt=6'b100000 the whole time, preempt never asserts, hold_cnt stays at 4.
- Release to idle: the sole owner drops req -> gnt=0 and gnt_valid=0 next edge; the next req[2] produces gnt[2] one cycle later.
- Reset mid-grant: nreset pulsed low while b1 is granted -> outputs 0 asynchronously; with req=6'b111111 after release, first grant is a0.
- Partial requests: req=6'b010101 -> all_req=1; req=6'b000011 -> all_req=0 one cycle later.

Source files
------------

// File: rtl/la_grparb222.sv
// la_grparb222: registered two-level round-robin arbiter for six requesters
// arranged as three groups of two (a0/a1, b0/b1, c0/c1). Groups rotate among
// themselves and members rotate inside their group. The owner keeps the grant
// until it drops its request or overstays the hold limit while others wait.
// A registered "every group requesting" flag is provided for the sequencers.
module la_grparb222 #(
    parameter string PROP     = "DEFAULT",
    parameter int    HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [5:0] req,
    output logic [5:0] gnt,
    output logic       gnt_valid,
    output logic [2:0] gnt_id,
    output logic       preempt,
    output logic       all_req
);

    if (HOLD_MAX < 0 || HOLD_MAX > 255) begin : g_bad_hold
        $error("la_grparb222: HOLD_MAX out of range 0..255");
    end

    // Hold limit as an 8-bit count; a zero limit means the owner is never forced off.
    localparam logic [7:0] HOLD_CAP = 8'(HOLD_MAX);
    localparam logic       HOLD_LIM = (HOLD_MAX != 0);
    // Where the counter parks while the owner is alone.
    localparam logic [7:0] HOLD_SAT = (HOLD_MAX == 0) ? 8'd255 : HOLD_CAP;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     state_r;
    logic [5:0] gnt_r;
    logic       gnt_valid_r;
    logic [2:0] gnt_id_r;
    logic       preempt_r;
    logic       all_req_r;
    logic [7:0] hold_cnt_r;
    logic [1:0] gptr_r;          // group that won last
    logic [2:0] mptr_r;          // per group: member that won last

    logic [5:0] elig_s;
    logic       owner_req_s;
    logic       limit_hit_s;
    logic [1:0] g_seq_s [3];
    logic       win_found_s;
    logic [2:0] win_idx_s;
    logic [5:0] win_onehot_s;
    logic       issue_s;
    logic       preempt_s;
    logic [7:0] hold_inc_s;

    // The owner is never a candidate; if it still requests we are rotating away from it.
    assign elig_s       = req & ~gnt_r;
    assign owner_req_s  = |(req & gnt_r);
    assign limit_hit_s  = HOLD_LIM && (hold_cnt_r >= HOLD_CAP);
    assign win_onehot_s = 6'b000001 << win_idx_s;
    // A new grant goes out from idle, on owner release, or when the owner overstays.
    assign issue_s      = win_found_s && (!owner_req_s || limit_hit_s);
    assign preempt_s    = issue_s && owner_req_s;

    // Group scan order starts at the group after the last winner.
    always_comb begin
        case (gptr_r)
            2'd0:    g_seq_s = '{2'd1, 2'd2, 2'd0};
            2'd1:    g_seq_s = '{2'd2, 2'd0, 2'd1};
            default: g_seq_s = '{2'd0, 2'd1, 2'd2};
        endcase
    end

    // Pick the first eligible requester: groups in rotation order, then the member after the last winner.
    always_comb begin : pick
        logic [2:0] cand;
        logic       mbit;
        cand        = 3'd0;
        mbit        = 1'b0;
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 2; j++) begin
                if (j == 0) begin
                    mbit = ~mptr_r[g_seq_s[k]];
                end else begin
                    mbit = mptr_r[g_seq_s[k]];
                end
                cand = {g_seq_s[k], mbit};
                if (!win_found_s && elig_s[cand]) begin
                    win_found_s = 1'b1;
                    win_idx_s   = cand;
                end else begin
                    win_found_s = win_found_s;
                end
            end
        end
    end

    // Hold counter advance: parks at the limit while alone, otherwise counts up to 255.
    always_comb begin
        if (!win_found_s && (hold_cnt_r >= HOLD_SAT)) begin
            hold_inc_s = HOLD_SAT;
        end else if (hold_cnt_r == 8'd255) begin
            hold_inc_s = 8'd255;
        end else begin
            hold_inc_s = hold_cnt_r + 8'd1;
        end
    end

    // Arbitration FSM with registered grant outputs and round-robin pointers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r     <= ST_IDLE;
            gnt_r       <= 6'd0;
            gnt_valid_r <= 1'b0;
            gnt_id_r    <= 3'd0;
            preempt_r   <= 1'b0;
            hold_cnt_r  <= 8'd0;
            gptr_r      <= 2'd2;
            mptr_r      <= 3'b111;
        end else if (issue_s) begin
            state_r                  <= ST_GRANT;
            gnt_r                    <= win_onehot_s;
            gnt_valid_r              <= 1'b1;
            gnt_id_r                 <= win_idx_s;
            preempt_r                <= preempt_s;
            hold_cnt_r               <= 8'd1;
            gptr_r                   <= win_idx_s[2:1];
            mptr_r[win_idx_s[2:1]]   <= win_idx_s[0];
        end else begin
            preempt_r <= 1'b0;
            case (state_r)
                ST_GRANT: begin
                    if (!owner_req_s) begin
                        state_r     <= ST_IDLE;
                        gnt_r       <= 6'd0;
                        gnt_valid_r <= 1'b0;
                        gnt_id_r    <= 3'd0;
                        hold_cnt_r  <= 8'd0;
                    end else begin
                        hold_cnt_r  <= hold_inc_s;
                    end
                end
                ST_IDLE: begin
                    gnt_r       <= 6'd0;
                    gnt_valid_r <= 1'b0;
                    gnt_id_r    <= 3'd0;
                    hold_cnt_r  <= 8'd0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    gnt_r       <= 6'd0;
                    gnt_valid_r <= 1'b0;
                    gnt_id_r    <= 3'd0;
                    hold_cnt_r  <= 8'd0;
                end
            endcase
        end
    end

    // Every-group-requesting flag, sampled every cycle regardless of arbitration.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            all_req_r <= 1'b0;
        end else begin
            all_req_r <= (|req[1:0]) & (|req[3:2]) & (|req[5:4]);
        end
    end

    assign gnt       = gnt_r;
    assign gnt_valid = gnt_valid_r;
    assign gnt_id    = gnt_id_r;
    assign preempt   = preempt_r;
    assign all_req   = all_req_r;

endmodule

// File: tb/tb_la_grparb222.sv
// Testbench for la_grparb222: directed scenarios plus random traffic, every
// cycle checked through a scoreboard fed by a behavioural reference model.
module tb_la_grparb222;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       nreset;
    logic [5:0] req;
    logic [5:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_id;
    logic       preempt;
    logic       all_req;

    always #5 clk = ~clk;

    la_grparb222 #(.PROP("DEFAULT"), .HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .preempt   (preempt),
        .all_req   (all_req)
    );

    typedef struct packed {
        logic [5:0] gnt;
        logic       valid;
        logic [2:0] id;
        logic       pre;
        logic       all;
    } obs_t;

    obs_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: owner index (-1 = none), last winning group and member per group.
    int m_owner;
    int m_gptr;
    int m_mptr [3];
    int m_hold;

    task automatic m_reset();
        m_owner = -1;
        m_gptr  = 2;
        for (int g = 0; g < 3; g++) m_mptr[g] = 1;
        m_hold  = 0;
    endtask

    function automatic bit req_bit(logic [5:0] v, int i);
        return ((v >> i) & 6'd1) != 6'd0;
    endfunction

    function automatic int m_pick(logic [5:0] elig);
        for (int k = 1; k <= 3; k++) begin
            int g = (m_gptr + k) % 3;
            for (int j = 0; j < 2; j++) begin
                int m = (m_mptr[g] + 1 + j) % 2;
                if (req_bit(elig, 2 * g + m)) return 2 * g + m;
            end
        end
        return -1;
    endfunction

    function automatic void m_give(int w);
        m_owner     = w;
        m_gptr      = w / 2;
        m_mptr[w/2] = w % 2;
        m_hold      = 1;
    endfunction

    function automatic obs_t m_step(logic [5:0] r);
        obs_t       e;
        logic [5:0] others;
        bit         owner_high;
        int         w;
        e.pre      = 1'b0;
        e.all      = (r[0] | r[1]) & (r[2] | r[3]) & (r[4] | r[5]);
        owner_high = (m_owner >= 0) && req_bit(r, m_owner);
        others     = (m_owner >= 0) ? (r & ~(6'd1 << m_owner)) : r;
        w          = m_pick(others);
        if (!owner_high) begin
            if (w >= 0) m_give(w);
            else begin m_owner = -1; m_hold = 0; end
        end else if (HOLD != 0 && m_hold >= HOLD && w >= 0) begin
            m_give(w);
            e.pre = 1'b1;
        end else if (w < 0) begin
            m_hold = (m_hold + 1 > ((HOLD == 0) ? 255 : HOLD)) ? ((HOLD == 0) ? 255 : HOLD) : m_hold + 1;
        end else begin
            m_hold = (m_hold + 1 > 255) ? 255 : m_hold + 1;
        end
        e.gnt   = (m_owner >= 0) ? (6'd1 << m_owner) : 6'd0;
        e.valid = (m_owner >= 0);
        e.id    = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        return e;
    endfunction

    // Drive one cycle of stimulus on the falling edge and queue what the next rising edge must show.
    task automatic step(input logic [5:0] r, input logic rst_v);
        @(negedge clk);
        nreset = rst_v;
        req    = r;
        if (!rst_v) begin
            m_reset();
            sbq.push_back('0);
        end else begin
            sbq.push_back(m_step(r));
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: one queued expectation is due just after every rising edge.
    initial begin
        obs_t exp_o;
        obs_t act_o;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                exp_o = sbq.pop_front();
                act_o = '{gnt, gnt_valid, gnt_id, preempt, all_req};
                vectors++;
                if (act_o !== exp_o) begin
                    miscompares++;
                    $display("FAIL scoreboard @%0t: got gnt=%b v=%b id=%0d pre=%b all=%b expected gnt=%b v=%b id=%0d pre=%b all=%b",
                             $time, act_o.gnt, act_o.valid, act_o.id, act_o.pre, act_o.all,
                             exp_o.gnt, exp_o.valid, exp_o.id, exp_o.pre, exp_o.all);
                end
            end
        end
    end

    initial begin
        int seq [7] = '{0, 2, 4, 1, 3, 5, 0};
        logic [5:0] pg [6] = '{6'b000001, 6'b000001, 6'b000001, 6'b000001, 6'b001000, 6'b001000};
        logic       pp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [5:0] pr [6] = '{6'b000001, 6'b000001, 6'b001001, 6'b001001, 6'b001001, 6'b001001};
        logic [5:0] r;

        nreset = 1'b0;
        req    = 6'd0;
        m_reset();
        #2;
        check("reset_state", int'({gnt, gnt_valid, gnt_id, preempt, all_req}), 0);

        // First grant after reset goes to a0, all_req follows one cycle later.
        step(6'b111111, 1'b1);
        after_edge();
        check("first_grant", int'({gnt, gnt_valid, gnt_id}), int'({6'b000001, 1'b1, 3'd0}));
        check("first_all_req", int'(all_req), 1);

        // Fairness: each owner drops for one cycle, order a0,b0,c0,a1,b1,c1,a0.
        step(6'd0, 1'b0);
        step(6'b111111, 1'b1);
        after_edge();
        check("fair_0", int'(gnt), 1);
        for (int i = 1; i < 7; i++) begin
            step(6'b111111 & ~(6'd1 << seq[i-1]), 1'b1);
            after_edge();
            check($sformatf("fair_%0d", i), int'({gnt, gnt_valid}), int'({6'd1 << seq[i], 1'b1}));
        end

        // Preemption: a0 held, b1 arrives; a0 keeps 4 cycles then b1 with a single preempt pulse.
        step(6'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(pr[i], 1'b1);
            after_edge();
            check($sformatf("preempt_cyc%0d", i), int'({gnt, preempt}), int'({pg[i], pp[i]}));
        end

        // Lone requester never preempted; counter parks at the limit, so a newcomer wins at once.
        step(6'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(6'b100000, 1'b1);
            after_edge();
            check("lone_hold", int'({gnt, preempt}), int'({6'b100000, 1'b0}));
        end
        step(6'b100001, 1'b1);
        after_edge();
        check("lone_then_rival", int'({gnt, preempt}), int'({6'b000001, 1'b1}));

        // Release to idle, then a fresh single request.
        step(6'd0, 1'b1);
        after_edge();
        check("release_idle", int'({gnt, gnt_valid}), 0);
        step(6'b000100, 1'b1);
        after_edge();
        check("after_idle", int'({gnt, gnt_id}), int'({6'b000100, 3'd2}));

        // Reset in the middle of a b1 grant clears outputs immediately; a0 wins first afterwards.
        step(6'd0, 1'b0);
        step(6'b001000, 1'b1);
        after_edge();
        check("b1_granted", int'(gnt), int'(6'b001000));
        step(6'b001000, 1'b0);
        #1;
        check("async_reset", int'({gnt, gnt_valid, gnt_id, preempt, all_req}), 0);
        step(6'b111111, 1'b1);
        after_edge();
        check("post_reset_a0", int'(gnt), 1);

        // Partial request patterns for the group flag.
        step(6'b010101, 1'b1);
        after_edge();
        check("all_req_010101", int'(all_req), 1);
        step(6'b000011, 1'b1);
        after_edge();
        check("all_req_000011", int'(all_req), 0);

        // Random traffic; the owner usually keeps requesting so hold limits come into play.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                step(6'($urandom), 1'b0);
            end else begin
                r = 6'($urandom) & 6'($urandom);
                if (m_owner >= 0 && $urandom_range(0, 3) != 0) r = r | (6'd1 << m_owner);
                step(r, 1'b1);
            end
        end

        after_edge();
        check("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
